// File: rtl/hex_word_packer.sv
`default_nettype none
// ============================================================================
// hex_word_packer: packs decoder byte writes into 16-bit LE words, FWFT FIFO out
// Revision: 1.0
// ============================================================================
module hex_word_packer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk_74a,
    input  logic                  reset_n,
    input  logic                  in_wr_en,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [7:0]            in_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-2:0] out_addr,
    output logic [15:0]           out_data,
    output logic [1:0]            out_be,
    output logic                  busy,
    output logic                  overflow
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W   = PTR_W - 1;
    localparam int WORD_W  = ADDR_WIDTH - 1;
    localparam int ENTRY_W = WORD_W + 2 + 16;

    logic              hold_valid_q, hold_valid_d;
    logic [WORD_W-1:0] hold_addr_q, hold_addr_d;
    logic [15:0]       hold_data_q, hold_data_d;
    logic [1:0]        hold_be_q, hold_be_d;
    logic              flush_pending_q, flush_pending_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic              overflow_q;

    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];

    logic               lane;
    logic [WORD_W-1:0]  word;
    logic [1:0]         lane_be;
    logic [15:0]        lane_data;
    logic               hit;
    logic [1:0]         merged_be;
    logic [15:0]        merged_data;
    logic               push;
    logic [ENTRY_W-1:0] push_entry;
    logic               fifo_empty;
    logic               fifo_full;
    logic               pop;
    logic               push_ok;
    logic [ENTRY_W-1:0] head;

    assign lane      = in_addr[0];
    assign word      = in_addr[ADDR_WIDTH-1:1];
    assign lane_be   = lane ? 2'b10 : 2'b01;
    assign lane_data = lane ? {in_data, 8'h00} : {8'h00, in_data};
    // A lane already written in the hold word is never overwritten: it evicts instead.
    assign hit       = hold_valid_q && (word == hold_addr_q) && !hold_be_q[lane];
    assign merged_be   = hold_be_q | lane_be;
    assign merged_data = lane ? {in_data, hold_data_q[7:0]} : {hold_data_q[15:8], in_data};

    always_comb begin
        hold_valid_d    = hold_valid_q;
        hold_addr_d     = hold_addr_q;
        hold_data_d     = hold_data_q;
        hold_be_d       = hold_be_q;
        flush_pending_d = flush_pending_q;
        push            = 1'b0;
        push_entry      = {hold_addr_q, hold_be_q, hold_data_q};
        if (in_wr_en) begin
            if (hit) begin
                hold_be_d   = merged_be;
                hold_data_d = merged_data;
                if (merged_be == 2'b11) begin
                    push         = 1'b1;
                    push_entry   = {hold_addr_q, 2'b11, merged_data};
                    hold_valid_d = 1'b0;
                    hold_be_d    = 2'b00;
                end
            end else begin
                push         = hold_valid_q;
                hold_valid_d = 1'b1;
                hold_addr_d  = word;
                hold_be_d    = lane_be;
                hold_data_d  = lane_data;
            end
            // Flush arriving with a byte runs one cycle later so only one push per cycle.
            flush_pending_d = flush_pending_q | flush;
        end else if (flush || flush_pending_q) begin
            push            = hold_valid_q;
            hold_valid_d    = 1'b0;
            hold_be_d       = 2'b00;
            flush_pending_d = 1'b0;
        end
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                        (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign pop        = !fifo_empty && out_ready;
    assign push_ok    = push && (!fifo_full || pop);

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid_q    <= 1'b0;
            hold_addr_q     <= '0;
            hold_data_q     <= '0;
            hold_be_q       <= 2'b00;
            flush_pending_q <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            overflow_q      <= 1'b0;
        end else begin
            hold_valid_q    <= hold_valid_d;
            hold_addr_q     <= hold_addr_d;
            hold_data_q     <= hold_data_d;
            hold_be_q       <= hold_be_d;
            flush_pending_q <= flush_pending_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_74a) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= push_entry;
        end
    end

    // Head entry is masked while empty so outputs read zero out of reset.
    assign head      = fifo_empty ? '0 : mem_q[rd_ptr_q[IDX_W-1:0]];
    assign out_valid = !fifo_empty;
    assign out_addr  = head[ENTRY_W-1:18];
    assign out_be    = head[17:16];
    assign out_data  = head[15:0];
    assign busy      = hold_valid_q | flush_pending_q | !fifo_empty;
    assign overflow  = overflow_q;

endmodule
`default_nettype wire
